// File: rtl/fb_pkg.sv
// Shared types and default geometry for the frame-buffer write stage.
package fb_pkg;

    localparam int FB_WIDTH_DEF  = 320;
    localparam int FB_HEIGHT_DEF = 180;
    localparam int FB_ADDR_W     = 1 + $clog2(FB_WIDTH_DEF * FB_HEIGHT_DEF);

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef enum logic {
        RUN       = 1'b0,
        WAIT_SWAP = 1'b1
    } fb_state_e;

    // Truncates each {R,G,B} byte of the renderer word to its RGB565 field.
    function automatic rgb565_t to_rgb565(input logic [23:0] rgb);
        rgb565_t p;
        p.r = rgb[23:19];
        p.g = rgb[15:10];
        p.b = rgb[7:3];
        return p;
    endfunction

endpackage

// File: rtl/fb_writer.sv
// Packs renderer pixels to RGB565 and writes them into a double-buffered frame
// buffer, stalling the renderer after each frame until display vsync swaps banks.
module fb_writer
    import fb_pkg::*;
#(
    parameter int FB_WIDTH  = FB_WIDTH_DEF,
    parameter int FB_HEIGHT = FB_HEIGHT_DEF,
    parameter int ADDR_W    = FB_ADDR_W
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [23:0]       pixel_axis_tdata,
    input  logic              pixel_axis_tvalid,
    output logic              pixel_axis_tready,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    input  logic              vsync_in,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [15:0]       fb_din,
    output logic              fb_we,
    output logic              write_bank,
    output logic              display_bank,
    output logic              frame_done,
    output logic [15:0]       dropped_count
);

    localparam int IDX_W = ADDR_W - 1;

    fb_state_e         state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       din_q;
    logic              we_q;
    logic              write_bank_q;
    logic              display_bank_q;
    logic              frame_done_q;
    logic [15:0]       dropped_q;

    logic              accept;
    logic              in_range;
    logic              last_pix;
    logic [IDX_W-1:0]  pix_idx_d;
    rgb565_t           din_d;

    // Ready is a pure decode of registered state, never of tvalid.
    assign pixel_axis_tready = (state_q == RUN);
    assign accept            = pixel_axis_tvalid && pixel_axis_tready;

    assign in_range = (hcount_in < 11'(FB_WIDTH)) && (vcount_in < 10'(FB_HEIGHT));
    assign last_pix = (hcount_in == 11'(FB_WIDTH - 1)) && (vcount_in == 10'(FB_HEIGHT - 1));

    // Row-major index, full width so no product bits are lost.
    assign pix_idx_d = IDX_W'(vcount_in) * IDX_W'(FB_WIDTH) + IDX_W'(hcount_in);
    assign din_d     = to_rgb565(pixel_axis_tdata);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q        <= RUN;
            addr_q         <= '0;
            din_q          <= '0;
            we_q           <= 1'b0;
            write_bank_q   <= 1'b1;
            display_bank_q <= 1'b0;
            frame_done_q   <= 1'b0;
            dropped_q      <= '0;
        end else begin
            we_q         <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if (accept) begin
                        if (in_range) begin
                            we_q   <= 1'b1;
                            addr_q <= {write_bank_q, pix_idx_d};
                            din_q  <= din_d;
                        end else if (dropped_q != 16'hFFFF) begin
                            dropped_q <= dropped_q + 16'd1;
                        end
                        if (last_pix) begin
                            frame_done_q <= 1'b1;
                            state_q      <= WAIT_SWAP;
                        end
                    end
                end
                WAIT_SWAP: begin
                    if (vsync_in) begin
                        write_bank_q   <= ~write_bank_q;
                        display_bank_q <= write_bank_q;
                        state_q        <= RUN;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign fb_addr       = addr_q;
    assign fb_din        = din_q;
    assign fb_we         = we_q;
    assign write_bank    = write_bank_q;
    assign display_bank  = display_bank_q;
    assign frame_done    = frame_done_q;
    assign dropped_count = dropped_q;

endmodule

// File: tb/tb_fb_writer.sv
// Directed bench for fb_writer: writes, drops, frame end, bank swap and reset.
module tb_fb_writer;

    logic        aclk;
    logic        aresetn;
    logic [23:0] tdata;
    logic        tvalid;
    logic        tready;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        vsync;
    logic [16:0] fb_addr;
    logic [15:0] fb_din;
    logic        fb_we;
    logic        write_bank;
    logic        display_bank;
    logic        frame_done;
    logic [15:0] dropped_count;

    int n_vec = 0;
    int n_err = 0;

    fb_writer dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .pixel_axis_tdata  (tdata),
        .pixel_axis_tvalid (tvalid),
        .pixel_axis_tready (tready),
        .hcount_in         (hcount),
        .vcount_in         (vcount),
        .vsync_in          (vsync),
        .fb_addr           (fb_addr),
        .fb_din            (fb_din),
        .fb_we             (fb_we),
        .write_bank        (write_bank),
        .display_bank      (display_bank),
        .frame_done        (frame_done),
        .dropped_count     (dropped_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Presents one beat for one edge; returns #1 after that edge with tvalid low.
    task automatic send(input logic [10:0] h, input logic [9:0] v, input logic [23:0] d);
        hcount = h;
        vcount = v;
        tdata  = d;
        tvalid = 1'b1;
        @(posedge aclk);
        #1;
        tvalid = 1'b0;
    endtask

    task automatic test_reset;
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        n_vec++; if (tready !== 1'b1) begin n_err++; $display("FAIL rst_tready got %b exp 1", tready); end
        n_vec++; if (write_bank !== 1'b1) begin n_err++; $display("FAIL rst_wbank got %b exp 1", write_bank); end
        n_vec++; if (display_bank !== 1'b0) begin n_err++; $display("FAIL rst_dbank got %b exp 0", display_bank); end
        n_vec++; if (fb_we !== 1'b0) begin n_err++; $display("FAIL rst_we got %b exp 0", fb_we); end
        n_vec++; if (fb_addr !== 17'h0) begin n_err++; $display("FAIL rst_addr got %h exp 0", fb_addr); end
        n_vec++; if (fb_din !== 16'h0) begin n_err++; $display("FAIL rst_din got %h exp 0", fb_din); end
        n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b exp 0", frame_done); end
        n_vec++; if (dropped_count !== 16'h0) begin n_err++; $display("FAIL rst_drop got %h exp 0", dropped_count); end
    endtask

    task automatic test_write;
        send(11'd0, 10'd0, 24'hFF8040);
        n_vec++; if (fb_we !== 1'b1) begin n_err++; $display("FAIL wr0_we got %b exp 1", fb_we); end
        n_vec++; if (fb_addr !== 17'h10000) begin n_err++; $display("FAIL wr0_addr got %h exp 10000", fb_addr); end
        n_vec++; if (fb_din !== 16'hFC08) begin n_err++; $display("FAIL wr0_din got %h exp fc08", fb_din); end
        n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL wr0_done got %b exp 0", frame_done); end
        @(posedge aclk);
        #1;
        n_vec++; if (fb_we !== 1'b0) begin n_err++; $display("FAIL wr0_we_drop got %b exp 0", fb_we); end
        n_vec++; if (fb_addr !== 17'h10000) begin n_err++; $display("FAIL wr0_addr_hold got %h exp 10000", fb_addr); end
        send(11'd5, 10'd2, 24'h123456);
        n_vec++; if (fb_addr !== 17'h10285) begin n_err++; $display("FAIL wr1_addr got %h exp 10285", fb_addr); end
        n_vec++; if (fb_din !== 16'h11AA) begin n_err++; $display("FAIL wr1_din got %h exp 11aa", fb_din); end
        // Back-to-back beats on consecutive edges, both at the raster edges.
        hcount = 11'd319; vcount = 10'd0; tdata = 24'h0000FF; tvalid = 1'b1;
        @(posedge aclk);
        #1;
        n_vec++; if (fb_addr !== 17'h1013F) begin n_err++; $display("FAIL wr2_addr got %h exp 1013f", fb_addr); end
        n_vec++; if (fb_din !== 16'h001F) begin n_err++; $display("FAIL wr2_din got %h exp 001f", fb_din); end
        hcount = 11'd318; vcount = 10'd179; tdata = 24'hFF0000;
        @(posedge aclk);
        #1;
        tvalid = 1'b0;
        n_vec++; if (fb_we !== 1'b1) begin n_err++; $display("FAIL wr3_we got %b exp 1", fb_we); end
        n_vec++; if (fb_addr !== 17'h1E0FE) begin n_err++; $display("FAIL wr3_addr got %h exp 1e0fe", fb_addr); end
        n_vec++; if (fb_din !== 16'hF800) begin n_err++; $display("FAIL wr3_din got %h exp f800", fb_din); end
        n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL wr3_done got %b exp 0", frame_done); end
    endtask

    task automatic test_drop;
        send(11'd320, 10'd0, 24'hFFFFFF);
        n_vec++; if (fb_we !== 1'b0) begin n_err++; $display("FAIL drop0_we got %b exp 0", fb_we); end
        n_vec++; if (tready !== 1'b1) begin n_err++; $display("FAIL drop0_tready got %b exp 1", tready); end
        send(11'd0, 10'd180, 24'hFFFFFF);
        n_vec++; if (fb_we !== 1'b0) begin n_err++; $display("FAIL drop1_we got %b exp 0", fb_we); end
        n_vec++; if (dropped_count !== 16'd2) begin n_err++; $display("FAIL drop_cnt2 got %h exp 0002", dropped_count); end
        n_vec++; if (fb_addr !== 17'h1E0FE) begin n_err++; $display("FAIL drop_addr_hold got %h exp 1e0fe", fb_addr); end
        n_vec++; if (fb_din !== 16'hF800) begin n_err++; $display("FAIL drop_din_hold got %h exp f800", fb_din); end
        // Stream out-of-range beats until the counter reaches its ceiling.
        hcount = 11'd500; vcount = 10'd0; tvalid = 1'b1;
        repeat (65533) @(posedge aclk);
        #1;
        tvalid = 1'b0;
        n_vec++; if (dropped_count !== 16'hFFFF) begin n_err++; $display("FAIL drop_cnt_max got %h exp ffff", dropped_count); end
        send(11'd2047, 10'd1023, 24'h0);
        n_vec++; if (dropped_count !== 16'hFFFF) begin n_err++; $display("FAIL drop_cnt_sat got %h exp ffff", dropped_count); end
        n_vec++; if (fb_we !== 1'b0) begin n_err++; $display("FAIL drop_sat_we got %b exp 0", fb_we); end
    endtask

    task automatic test_frame_end;
        hcount = 11'd319; vcount = 10'd179; tdata = 24'h00FF00; tvalid = 1'b1;
        @(posedge aclk);
        #1;
        n_vec++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL fe_done got %b exp 1", frame_done); end
        n_vec++; if (fb_we !== 1'b1) begin n_err++; $display("FAIL fe_we got %b exp 1", fb_we); end
        n_vec++; if (fb_addr !== 17'h1E0FF) begin n_err++; $display("FAIL fe_addr got %h exp 1e0ff", fb_addr); end
        n_vec++; if (fb_din !== 16'h07E0) begin n_err++; $display("FAIL fe_din got %h exp 07e0", fb_din); end
        n_vec++; if (tready !== 1'b0) begin n_err++; $display("FAIL fe_tready got %b exp 0", tready); end
        // tvalid stays high with an in-range pixel while the stage is stalled.
        hcount = 11'd10; vcount = 10'd10;
        for (int i = 0; i < 4; i++) begin
            @(posedge aclk);
            #1;
            n_vec++; if (fb_we !== 1'b0) begin n_err++; $display("FAIL fe_stall_we%0d got %b exp 0", i, fb_we); end
            n_vec++; if (tready !== 1'b0) begin n_err++; $display("FAIL fe_stall_rdy%0d got %b exp 0", i, tready); end
            n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL fe_stall_done%0d got %b exp 0", i, frame_done); end
            n_vec++; if (write_bank !== 1'b1) begin n_err++; $display("FAIL fe_stall_bank%0d got %b exp 1", i, write_bank); end
        end
        vsync = 1'b1;
        @(posedge aclk);
        #1;
        vsync  = 1'b0;
        tvalid = 1'b0;
        n_vec++; if (write_bank !== 1'b0) begin n_err++; $display("FAIL fe_swap_wbank got %b exp 0", write_bank); end
        n_vec++; if (display_bank !== 1'b1) begin n_err++; $display("FAIL fe_swap_dbank got %b exp 1", display_bank); end
        n_vec++; if (tready !== 1'b1) begin n_err++; $display("FAIL fe_swap_tready got %b exp 1", tready); end
        n_vec++; if (fb_we !== 1'b0) begin n_err++; $display("FAIL fe_swap_we got %b exp 0", fb_we); end
        send(11'd5, 10'd2, 24'h123456);
        n_vec++; if (fb_addr !== 17'h00285) begin n_err++; $display("FAIL bank0_addr got %h exp 00285", fb_addr); end
        n_vec++; if (fb_we !== 1'b1) begin n_err++; $display("FAIL bank0_we got %b exp 1", fb_we); end
    endtask

    task automatic test_reset_in_wait;
        send(11'd319, 10'd179, 24'h808080);
        n_vec++; if (fb_addr !== 17'h0E0FF) begin n_err++; $display("FAIL rw_addr got %h exp 0e0ff", fb_addr); end
        n_vec++; if (tready !== 1'b0) begin n_err++; $display("FAIL rw_tready got %b exp 0", tready); end
        #2;
        aresetn = 1'b0;
        #1;
        n_vec++; if (tready !== 1'b1) begin n_err++; $display("FAIL rw_async_tready got %b exp 1", tready); end
        n_vec++; if (write_bank !== 1'b1) begin n_err++; $display("FAIL rw_async_wbank got %b exp 1", write_bank); end
        n_vec++; if (display_bank !== 1'b0) begin n_err++; $display("FAIL rw_async_dbank got %b exp 0", display_bank); end
        n_vec++; if (fb_we !== 1'b0) begin n_err++; $display("FAIL rw_async_we got %b exp 0", fb_we); end
        n_vec++; if (fb_addr !== 17'h0) begin n_err++; $display("FAIL rw_async_addr got %h exp 0", fb_addr); end
        n_vec++; if (fb_din !== 16'h0) begin n_err++; $display("FAIL rw_async_din got %h exp 0", fb_din); end
        n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL rw_async_done got %b exp 0", frame_done); end
        n_vec++; if (dropped_count !== 16'h0) begin n_err++; $display("FAIL rw_async_drop got %h exp 0", dropped_count); end
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        n_vec++; if (tready !== 1'b1) begin n_err++; $display("FAIL rw_post_tready got %b exp 1", tready); end
    endtask

    task automatic test_vsync_ignored;
        vsync = 1'b1;
        @(posedge aclk);
        #1;
        vsync = 1'b0;
        n_vec++; if (write_bank !== 1'b1) begin n_err++; $display("FAIL vrun_wbank got %b exp 1", write_bank); end
        n_vec++; if (tready !== 1'b1) begin n_err++; $display("FAIL vrun_tready got %b exp 1", tready); end
        // vsync coincident with the last-pixel edge must not swap.
        vsync = 1'b1;
        send(11'd319, 10'd179, 24'h000000);
        vsync = 1'b0;
        n_vec++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL vsame_done got %b exp 1", frame_done); end
        n_vec++; if (write_bank !== 1'b1) begin n_err++; $display("FAIL vsame_wbank got %b exp 1", write_bank); end
        n_vec++; if (tready !== 1'b0) begin n_err++; $display("FAIL vsame_tready got %b exp 0", tready); end
        n_vec++; if (fb_addr !== 17'h1E0FF) begin n_err++; $display("FAIL vsame_addr got %h exp 1e0ff", fb_addr); end
        for (int i = 0; i < 2; i++) begin
            @(posedge aclk);
            #1;
            n_vec++; if (write_bank !== 1'b1) begin n_err++; $display("FAIL vwait_wbank%0d got %b exp 1", i, write_bank); end
            n_vec++; if (tready !== 1'b0) begin n_err++; $display("FAIL vwait_tready%0d got %b exp 0", i, tready); end
        end
        vsync = 1'b1;
        @(posedge aclk);
        #1;
        vsync = 1'b0;
        n_vec++; if (write_bank !== 1'b0) begin n_err++; $display("FAIL v2_wbank got %b exp 0", write_bank); end
        n_vec++; if (display_bank !== 1'b1) begin n_err++; $display("FAIL v2_dbank got %b exp 1", display_bank); end
        n_vec++; if (tready !== 1'b1) begin n_err++; $display("FAIL v2_tready got %b exp 1", tready); end
    endtask

    initial begin
        aresetn = 1'b0;
        tdata   = '0;
        tvalid  = 1'b0;
        hcount  = '0;
        vcount  = '0;
        vsync   = 1'b0;
        test_reset;
        test_write;
        test_drop;
        test_frame_end;
        test_reset_in_wait;
        test_vsync_ignored;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fb_writer.md
# fb_writer

Frame-buffer write stage directly downstream of the ray-tracing renderer. It consumes the renderer's 24-bit pixel stream together with the delayed hcount/vcount, packs each pixel to RGB565, and writes it into a double-buffered BRAM frame buffer. At the end of each rendered frame it holds off the renderer until the display side reaches vsync, then swaps the banks, so the displayed bank is never written.

## Interface

Parameters:
- FB_WIDTH, 320: frame-buffer columns.
- FB_HEIGHT, 180: frame-buffer rows.
- ADDR_W, 17: write-address width; 1 bank bit + clog2(FB_WIDTH*FB_HEIGHT).

Ports:
- aclk  in  1  single clock for all logic.
- aresetn  in  1  reset, asynchronous, active-low.
- pixel_axis_tdata  in  24  {R[23:16], G[15:8], B[7:0]} from the renderer.
- pixel_axis_tvalid  in  1  pixel beat valid.
- pixel_axis_tready  out  1  high only in state RUN.
- hcount_in  in  11  pixel column, qualified by tvalid.
- vcount_in  in  10  pixel row, qualified by tvalid.
- vsync_in  in  1  single-cycle display-side vsync pulse on aclk.
- fb_addr  out  ADDR_W  {write_bank, vcount*FB_WIDTH + hcount}.
- fb_din  out  16  RGB565 pixel.
- fb_we  out  1  BRAM write enable.
- write_bank  out  1  bank currently being written.
- display_bank  out  1  bank the display reads; always ~write_bank.
- frame_done  out  1  one-cycle pulse when the last pixel is written.
- dropped_count  out  16  saturating count of out-of-range beats.

## Operation

- A beat is accepted when tvalid && tready.
- States:
  - RUN: tready=1.
  - WAIT_SWAP: tready=0.
- In-range beat (hcount_in < FB_WIDTH and vcount_in < FB_HEIGHT):
  - Register fb_we=1.
  - fb_addr = {write_bank, vcount*FB_WIDTH + hcount}; the multiply is by a constant, and the sum is computed at ADDR_W-1 bits with no truncation.
  - fb_din = {R[7:3], G[7:2], B[7:3]}.
- Out-of-range beat: the handshake completes but no write occurs. dropped_count increments and saturates at 16'hFFFF.
- Last pixel (hcount_in==FB_WIDTH-1 and vcount_in==FB_HEIGHT-1, accepted): write it, pulse frame_done, go to WAIT_SWAP.
- WAIT_SWAP with vsync_in=1:
  - write_bank <= ~write_bank, display_bank <= write_bank.
  - Return to RUN.
- vsync_in in RUN is ignored. A vsync in the same cycle the last pixel is accepted is also ignored; the block waits for the next vsync.
- Pixels are not required to arrive in raster order. Only the last-pixel coordinate ends a frame. Duplicate coordinates overwrite.

## Timing

- Reset values:
  - state RUN, tready 1.
  - write_bank 1, display_bank 0.
  - fb_we 0, fb_addr 0, fb_din 0.
  - frame_done 0, dropped_count 0.
- Latency: a beat accepted at cycle N produces fb_we/fb_addr/fb_din at N+1 (one register stage). frame_done also pulses at N+1, and tready is low from N+1.
- fb_we is high for exactly one cycle per in-range accepted beat. Otherwise it is 0; fb_addr and fb_din hold their last values.
- vsync at cycle M in WAIT_SWAP: banks swap at M+1, and tready=1 from M+1.
- Minimum stall is 1 cycle: the last pixel is accepted at N and vsync arrives at N+1.
- Reset mid-frame or mid-WAIT_SWAP returns immediately to the reset values. Buffer contents are not cleared.
- tready does not depend combinationally on tvalid; it is a decode of registered state only.

## Structure

- Shared package fb_pkg:
  - typedef rgb565_t (16-bit packed struct r/g/b).
  - FB_WIDTH/FB_HEIGHT defaults and the ADDR_W localparam.
  - function to_rgb565(24-bit) returning rgb565_t.
- Single module with one FSM (enum {RUN, WAIT_SWAP}) and one output register stage. No sub-module is needed; the BRAM is instantiated by the parent.

## Test plan

- Reset, then beat (h=0, v=0, 24'hFF8040) -> next cycle fb_we=1, fb_addr=17'h10000, fb_din=16'hFC08.
- Beat (h=5, v=2) on bank 1 -> fb_addr = 17'h10000 + 645 = 17'h10285.
- Beat (h=320, v=0), then (h=0, v=180) -> no fb_we, dropped_count=2. Preload 16'hFFFF, send one more out-of-range beat -> count stays 16'hFFFF.
- Beat (h=319, v=179) at cycle N:
  - frame_done at N+1, tready=0 from N+1.
  - tvalid held high makes no further writes.
  - vsync at N+5 -> write_bank=0, display_bank=1 at N+6, tready=1 at N+6.
- vsync in the same cycle as the last-pixel acceptance -> no swap. A second vsync 3 cycles later -> swap.
- Assert aresetn=0 during WAIT_SWAP -> all outputs at reset values in the same cycle, tready=1 after release.
